// File: rtl/rps_match_scoreboard_if.sv
// Round-result handshake between the round judge and the match scoreboard.
// The judge drives result/result_valid; the scoreboard answers with result_ready.
interface rps_match_scoreboard_if;
  logic [1:0] result;
  logic       result_valid;
  logic       result_ready;

  modport master (
    output result,
    output result_valid,
    input  result_ready
  );

  modport slave (
    input  result,
    input  result_valid,
    output result_ready
  );
endinterface

// File: rtl/rps_match_scoreboard.sv
// Match scoreboard for stone-paper-scissors: tallies round results and
// declares a winner on target score, round limit or invalid-move streak.
module rps_match_scoreboard #(
  parameter int WIN_TARGET    = 3,
  parameter int MAX_ROUNDS    = 5,
  parameter int INVALID_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  rps_match_scoreboard_if.slave bus,
  input  logic                  new_match,
  output logic [3:0]            p1_score,
  output logic [3:0]            p2_score,
  output logic [3:0]            round_cnt,
  output logic [3:0]            invalid_streak,
  output logic                  match_over,
  output logic [1:0]            match_winner,
  output logic                  match_abort,
  output logic                  match_done_pulse
);

  if (WIN_TARGET < 1 || WIN_TARGET > 15) begin : g_bad_win
    $fatal(1, "WIN_TARGET out of range 1..15");
  end
  if (MAX_ROUNDS < 1 || MAX_ROUNDS > 15) begin : g_bad_rounds
    $fatal(1, "MAX_ROUNDS out of range 1..15");
  end
  if (INVALID_LIMIT < 1 || INVALID_LIMIT > 15) begin : g_bad_inv
    $fatal(1, "INVALID_LIMIT out of range 1..15");
  end

  localparam logic [3:0] WIN_L = 4'(WIN_TARGET);
  localparam logic [3:0] RND_L = 4'(MAX_ROUNDS);
  localparam logic [3:0] INV_L = 4'(INVALID_LIMIT);

  localparam logic [1:0] W_DRAW = 2'b00;
  localparam logic [1:0] W_P1   = 2'b01;
  localparam logic [1:0] W_P2   = 2'b10;
  localparam logic [1:0] W_NONE = 2'b11;

  typedef enum logic {PLAY, DONE} state_t;

  state_t     state, state_n;
  logic [3:0] p1_n, p2_n, rnd_n, inv_n;
  logic       over_n, abort_n, pulse_n;
  logic [1:0] winner_n;
  logic       accept;

  assign bus.result_ready = (state == PLAY) && !new_match;
  assign accept = bus.result_valid && bus.result_ready;

  always_comb begin
    state_n  = state;
    p1_n     = p1_score;
    p2_n     = p2_score;
    rnd_n    = round_cnt;
    inv_n    = invalid_streak;
    over_n   = match_over;
    winner_n = match_winner;
    abort_n  = match_abort;
    pulse_n  = 1'b0;

    if (new_match) begin
      state_n  = PLAY;
      p1_n     = '0;
      p2_n     = '0;
      rnd_n    = '0;
      inv_n    = '0;
      over_n   = 1'b0;
      winner_n = W_NONE;
      abort_n  = 1'b0;
    end else if (accept) begin
      unique case (bus.result)
        2'b01: begin
          p1_n  = p1_score + 4'd1;
          rnd_n = round_cnt + 4'd1;
          inv_n = '0;
        end
        2'b10: begin
          p2_n  = p2_score + 4'd1;
          rnd_n = round_cnt + 4'd1;
          inv_n = '0;
        end
        2'b00: begin
          rnd_n = round_cnt + 4'd1;
          inv_n = '0;
        end
        default: inv_n = invalid_streak + 4'd1;
      endcase

      // End checks look at post-update values, score first.
      if (p1_n == WIN_L) begin
        over_n   = 1'b1;
        winner_n = W_P1;
      end else if (p2_n == WIN_L) begin
        over_n   = 1'b1;
        winner_n = W_P2;
      end else if (rnd_n == RND_L) begin
        over_n = 1'b1;
        unique case (1'b1)
          (p1_n > p2_n): winner_n = W_P1;
          (p2_n > p1_n): winner_n = W_P2;
          default:       winner_n = W_DRAW;
        endcase
      end else if (inv_n == INV_L) begin
        over_n   = 1'b1;
        winner_n = W_DRAW;
        abort_n  = 1'b1;
      end

      if (over_n) begin
        state_n = DONE;
        pulse_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= PLAY;
      p1_score         <= '0;
      p2_score         <= '0;
      round_cnt        <= '0;
      invalid_streak   <= '0;
      match_over       <= 1'b0;
      match_winner     <= W_NONE;
      match_abort      <= 1'b0;
      match_done_pulse <= 1'b0;
    end else begin
      state            <= state_n;
      p1_score         <= p1_n;
      p2_score         <= p2_n;
      round_cnt        <= rnd_n;
      invalid_streak   <= inv_n;
      match_over       <= over_n;
      match_winner     <= winner_n;
      match_abort      <= abort_n;
      match_done_pulse <= pulse_n;
    end
  end

endmodule

// File: tb/tb_rps_match_scoreboard.sv
// Randomized and directed bench for rps_match_scoreboard against a
// match-level reference model of the scoring rules.
module tb_rps_match_scoreboard;

  localparam int WIN = 3;
  localparam int MAXR = 5;
  localparam int LIM = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       new_match = 1'b0;
  logic [3:0] p1_score, p2_score, round_cnt, invalid_streak;
  logic       match_over, match_abort, match_done_pulse;
  logic [1:0] match_winner;

  int errors = 0;
  int checks = 0;

  rps_match_scoreboard_if bus();

  rps_match_scoreboard #(
    .WIN_TARGET(WIN),
    .MAX_ROUNDS(MAXR),
    .INVALID_LIMIT(LIM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .new_match(new_match),
    .p1_score(p1_score),
    .p2_score(p2_score),
    .round_cnt(round_cnt),
    .invalid_streak(invalid_streak),
    .match_over(match_over),
    .match_winner(match_winner),
    .match_abort(match_abort),
    .match_done_pulse(match_done_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: match tallies as plain integers
  int m_p1, m_p2, m_rounds, m_streak, m_winner;
  bit m_over, m_abort, m_pulse;

  function automatic void model_reset();
    m_p1 = 0; m_p2 = 0; m_rounds = 0; m_streak = 0;
    m_over = 0; m_abort = 0; m_pulse = 0; m_winner = 3;
  endfunction

  function automatic void model_edge(bit v, logic [1:0] r, bit nm);
    m_pulse = 0;
    if (nm) begin
      model_reset();
      return;
    end
    if (!v || m_over) return;
    if (r == 2'b11) m_streak++;
    else begin
      m_rounds++;
      m_streak = 0;
      if (r == 2'b01) m_p1++;
      if (r == 2'b10) m_p2++;
    end
    if (m_p1 == WIN) begin
      m_over = 1; m_winner = 1;
    end else if (m_p2 == WIN) begin
      m_over = 1; m_winner = 2;
    end else if (m_rounds == MAXR) begin
      m_over = 1;
      m_winner = (m_p1 > m_p2) ? 1 : (m_p2 > m_p1) ? 2 : 0;
    end else if (m_streak == LIM) begin
      m_over = 1; m_winner = 0; m_abort = 1;
    end
    if (m_over) m_pulse = 1;
  endfunction

  function automatic logic [21:0] got_vec();
    return {p1_score, p2_score, round_cnt, invalid_streak, match_over,
            match_winner, match_abort, match_done_pulse, bus.result_ready};
  endfunction

  function automatic logic [21:0] exp_vec();
    return {4'(m_p1), 4'(m_p2), 4'(m_rounds), 4'(m_streak), m_over,
            2'(m_winner), m_abort, m_pulse, !m_over && !new_match};
  endfunction

  task automatic drive(input logic [1:0] r, input bit v, input bit nm);
    @(negedge clk);
    bus.result = r;
    bus.result_valid = v;
    new_match = nm;
    @(posedge clk);
    model_edge(v, r, nm);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (got_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset: got %h want %h", got_vec(), exp_vec());
    end
  endtask

  task automatic test_p1_win();
    drive(2'b00, 0, 1);
    for (int i = 0; i < 3; i++) begin
      drive(2'b01, 1, 0);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL p1_win[%0d]: got %h want %h", i, got_vec(), exp_vec());
      end
    end
    checks++;
    if ({match_over, match_winner, match_done_pulse} !== 4'b1011) begin
      errors++;
      $display("FAIL p1_win_end: got %b want 1011",
               {match_over, match_winner, match_done_pulse});
    end
    drive(2'b00, 0, 0);
    checks++;
    if (match_done_pulse !== 1'b0 || bus.result_ready !== 1'b0) begin
      errors++;
      $display("FAIL p1_win_after: got pulse=%b ready=%b want 0 0",
               match_done_pulse, bus.result_ready);
    end
  endtask

  task automatic run_seq(input string name, input logic [1:0] s[$]);
    drive(2'b00, 0, 1);
    foreach (s[i]) begin
      drive(s[i], 1, 0);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL %s[%0d]: got %h want %h", name, i, got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_round_limit();
    run_seq("round_limit", '{2'b01, 2'b10, 2'b00, 2'b10, 2'b00});
    checks++;
    if ({round_cnt, p1_score, p2_score, match_winner, match_abort}
        !== {4'd5, 4'd1, 4'd2, 2'b10, 1'b0}) begin
      errors++;
      $display("FAIL round_limit_end: got r=%0d p1=%0d p2=%0d w=%b a=%b",
               round_cnt, p1_score, p2_score, match_winner, match_abort);
    end
  endtask

  task automatic test_abort();
    run_seq("abort", '{2'b01, 2'b11, 2'b11, 2'b11});
    checks++;
    if ({match_over, match_winner, match_abort, p1_score, round_cnt}
        !== {1'b1, 2'b00, 1'b1, 4'd1, 4'd1}) begin
      errors++;
      $display("FAIL abort_end: got o=%b w=%b a=%b p1=%0d r=%0d",
               match_over, match_winner, match_abort, p1_score, round_cnt);
    end
  endtask

  task automatic test_streak_reset();
    run_seq("streak", '{2'b11, 2'b11, 2'b01});
    checks++;
    if (invalid_streak !== 4'd0 || match_over !== 1'b0) begin
      errors++;
      $display("FAIL streak_clear: got streak=%0d over=%b want 0 0",
               invalid_streak, match_over);
    end
  endtask

  task automatic test_draw();
    run_seq("draw", '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10});
    checks++;
    if ({p1_score, p2_score, match_winner, match_over}
        !== {4'd2, 4'd2, 2'b00, 1'b1}) begin
      errors++;
      $display("FAIL draw_end: got p1=%0d p2=%0d w=%b o=%b",
               p1_score, p2_score, match_winner, match_over);
    end
  endtask

  task automatic test_done_ignore();
    for (int i = 0; i < 4; i++) begin
      drive(2'b01, 1, 0);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL done_ignore[%0d]: got %h want %h",
                 i, got_vec(), exp_vec());
      end
    end
    drive(2'b01, 1, 1);
    checks++;
    if ({p1_score, p2_score, round_cnt, invalid_streak, match_over,
         match_winner, match_abort} !== {16'd0, 1'b0, 2'b11, 1'b0}) begin
      errors++;
      $display("FAIL new_match_clear: got %h want %h", got_vec(), exp_vec());
    end
    drive(2'b00, 0, 0);
    checks++;
    if (bus.result_ready !== 1'b1 || p1_score !== 4'd0) begin
      errors++;
      $display("FAIL new_match_play: got ready=%b p1=%0d want 1 0",
               bus.result_ready, p1_score);
    end
  endtask

  task automatic test_async_reset();
    drive(2'b00, 0, 1);
    drive(2'b01, 1, 0);
    drive(2'b01, 1, 0);
    @(negedge clk);
    bus.result_valid = 0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (got_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL async_reset: got %h want %h", got_vec(), exp_vec());
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.result_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b want 1", bus.result_ready);
    end
  endtask

  task automatic test_random();
    drive(2'b00, 0, 1);
    for (int i = 0; i < 400; i++) begin
      drive(2'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random[%0d]: got %h want %h", i, got_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    bus.result = 2'b00;
    bus.result_valid = 1'b0;
    model_reset();
    #12 rst = 1'b0;
    #1;
    test_reset();
    test_p1_win();
    test_round_limit();
    test_abort();
    test_streak_reset();
    test_draw();
    test_done_ignore();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
